// File: rtl/axis_uart_tx_if.sv
// Valid/ready word channel feeding the UART transmitter.
interface axis_uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] idata;
  logic                 ivalid;
  logic                 iready;

  modport master (output idata, output ivalid, input  iready);
  modport slave  (input  idata, input  ivalid, output iready);
endinterface

// File: rtl/axis_uart_tx.sv
// RS232 transmitter: accepts words on a valid/ready channel and serialises them
// with a configurable frame format, optional parity and optional CTS gating.
module axis_uart_tx #(
  parameter real         CLOCK_FREQ = 133000000.0,
  parameter real         BAUD_RATE  = 115200.0,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned USE_CTS    = 1
) (
  input  logic           clock,
  input  logic           resetn,
  axis_uart_tx_if.slave  s_axis,
  output logic           txd_pin,
  input  logic           ctsn_pin,
  output logic           busy
);

  localparam int unsigned BAUD_COUNT = $rtoi(CLOCK_FREQ / BAUD_RATE + 0.5);
  localparam int unsigned CNT_W      = $clog2(BAUD_COUNT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_COUNT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Reject parameter sets the bit timing or frame counters cannot represent.
  if (BAUD_COUNT < 2) begin : g_bad_baud
    $error("axis_uart_tx: CLOCK_FREQ/BAUD_RATE must round to at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("axis_uart_tx: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("axis_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("axis_uart_tx: STOP_BITS must be 1 or 2");
  end

  logic [2:0]           state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [3:0]           bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic                 parity_q,    parity_d;
  logic                 txd_q,       txd_d;
  logic                 busy_q,      busy_d;
  logic                 iready_q,    iready_d;
  logic [1:0]           ctsn_sync_q, ctsn_sync_d;

  logic cts_ok_c;
  logic accept_c;
  logic start_c;

  assign cts_ok_c = (USE_CTS != 0) ? ~ctsn_sync_q[1] : 1'b1;
  assign accept_c = iready_q & s_axis.ivalid;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    txd_d       = txd_q;
    busy_d      = busy_q;
    iready_d    = 1'b0;
    ctsn_sync_d = {ctsn_sync_q[0], ctsn_pin};
    start_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        txd_d    = 1'b1;
        busy_d   = 1'b0;
        iready_d = cts_ok_c;
        if (accept_c) begin
          start_c = 1'b1;
        end
      end

      ST_START: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d   = ST_DATA;
          cnt_d     = CNT_RELOAD;
          bit_idx_d = 4'd0;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end

      ST_DATA: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = 4'd0;
            if (PARITY != 0) begin
              state_d = ST_PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end

      ST_PARITY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d   = ST_STOP;
          cnt_d     = CNT_RELOAD;
          bit_idx_d = 4'd0;
          txd_d     = 1'b1;
        end
      end

      ST_STOP: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Open the window one cycle early so iready is high in the final stop cycle.
        if (bit_idx_q == LAST_STOP && cnt_q == CNT_W'(1)) begin
          iready_d = cts_ok_c;
        end
        if (cnt_q == '0) begin
          if (bit_idx_q == LAST_STOP) begin
            if (accept_c) begin
              start_c = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              busy_d   = 1'b0;
              txd_d    = 1'b1;
              iready_d = cts_ok_c;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            cnt_d     = CNT_RELOAD;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Frame launch shared by the idle path and the back-to-back path.
    if (start_c) begin
      state_d   = ST_START;
      cnt_d     = CNT_RELOAD;
      bit_idx_d = 4'd0;
      shift_d   = s_axis.idata;
      parity_d  = (PARITY == 1) ? ~^s_axis.idata : ^s_axis.idata;
      txd_d     = 1'b0;
      busy_d    = 1'b1;
      iready_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 4'd0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      iready_q    <= 1'b0;
      ctsn_sync_q <= 2'b11;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      iready_q    <= iready_d;
      ctsn_sync_q <= ctsn_sync_d;
    end
  end

  assign txd_pin       = txd_q;
  assign busy          = busy_q;
  assign s_axis.iready = iready_q;

endmodule
